// File: rtl/ram_arb_dp.sv
// ram_arb_dp: two-port RAM, A/B arbitrated req/ack with byte lanes and WAIT wait states.
// RAM_RR_ARB_EN selects round-robin arbitration; otherwise port A has fixed priority.
module ram_arb_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int WAIT  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_x,
  input  logic               i_a_req,
  input  logic               i_a_write_x,
  input  logic [DEPTH-1:0]   i_a_addr,
  input  logic [WIDTH-1:0]   i_a_data,
  input  logic [WIDTH/8-1:0] i_a_be,
  output logic               o_a_ack,
  output logic [WIDTH-1:0]   o_a_data,
  input  logic               i_b_req,
  input  logic               i_b_write_x,
  input  logic [DEPTH-1:0]   i_b_addr,
  input  logic [WIDTH-1:0]   i_b_data,
  input  logic [WIDTH/8-1:0] i_b_be,
  output logic               o_b_ack,
  output logic [WIDTH-1:0]   o_b_data,
  output logic               o_busy
);
  localparam int NB = WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t           state;
  logic [7:0]       cnt;
  logic             gnt_b, we, pick_b, commit;
  logic [DEPTH-1:0] addr;
  logic [WIDTH-1:0] data;
  logic [NB-1:0]    be;
  logic [WIDTH-1:0] mem [2**DEPTH];
`ifdef RAM_RR_ARB_EN
  logic last_b;
  assign pick_b = i_b_req && (!i_a_req || !last_b);
`else
  assign pick_b = i_b_req && !i_a_req;
`endif
  assign commit = (state == ACCESS) && (cnt == 8'd0);
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_x)
    if (!i_rst_x) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_b    <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      data     <= '0;
      be       <= '0;
      o_a_ack  <= 1'b0;
      o_b_ack  <= 1'b0;
      o_a_data <= '0;
      o_b_data <= '0;
`ifdef RAM_RR_ARB_EN
      last_b   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (i_a_req || i_b_req) begin
          state <= ACCESS;
          cnt   <= 8'(WAIT);
          gnt_b <= pick_b;
          we    <= pick_b ? !i_b_write_x : !i_a_write_x;
          addr  <= pick_b ? i_b_addr : i_a_addr;
          data  <= pick_b ? i_b_data : i_a_data;
          be    <= pick_b ? i_b_be : i_a_be;
`ifdef RAM_RR_ARB_EN
          last_b <= pick_b;
`endif
        end
        ACCESS: if (cnt == 8'd0) begin
          state   <= DONE;
          o_a_ack <= !gnt_b;
          o_b_ack <= gnt_b;
          if (!we && gnt_b) o_b_data <= mem[addr];
          if (!we && !gnt_b) o_a_data <= mem[addr];
        end else begin
          cnt <= cnt - 8'd1;
        end
        DONE: begin
          state   <= IDLE;
          o_a_ack <= 1'b0;
          o_b_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // Storage has no reset; a reset mid-ACCESS forces IDLE, so commit never fires for it.
  always_ff @(posedge i_clk)
    if (commit && we)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[addr][8*i +: 8] <= data[8*i +: 8];
endmodule

// File: tb/tb_ram_arb_dp.sv
// tb_ram_arb_dp: directed checks of ram_arb_dp (WIDTH=16/WAIT=2 and WIDTH=8/WAIT=0 instances).
module tb_ram_arb_dp;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        a_req = 0, a_wx = 1, b_req = 0, b_wx = 1, a_ack, b_ack, busy;
  logic [7:0]  a_addr = 0, b_addr = 0;
  logic [15:0] a_data = 0, b_data = 0, a_q, b_q;
  logic [1:0]  a_be = 0, b_be = 0;
  logic        z_a_req = 0, z_a_wx = 1, z_b_req = 0, z_b_wx = 1, z_a_ack, z_b_ack, z_busy;
  logic [3:0]  z_a_addr = 0, z_b_addr = 0;
  logic [7:0]  z_a_data = 0, z_b_data = 0, z_a_q, z_b_q;
  logic [0:0]  z_a_be = 0, z_b_be = 0;
  int total = 0, bad = 0;
  ram_arb_dp #(.WIDTH(16), .DEPTH(8), .WAIT(2)) dut (
    .i_clk(clk), .i_rst_x(rst_n),
    .i_a_req(a_req), .i_a_write_x(a_wx), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_be(a_be),
    .o_a_ack(a_ack), .o_a_data(a_q),
    .i_b_req(b_req), .i_b_write_x(b_wx), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_be(b_be),
    .o_b_ack(b_ack), .o_b_data(b_q), .o_busy(busy));
  ram_arb_dp #(.WIDTH(8), .DEPTH(4), .WAIT(0)) dut0 (
    .i_clk(clk), .i_rst_x(rst_n),
    .i_a_req(z_a_req), .i_a_write_x(z_a_wx), .i_a_addr(z_a_addr), .i_a_data(z_a_data), .i_a_be(z_a_be),
    .o_a_ack(z_a_ack), .o_a_data(z_a_q),
    .i_b_req(z_b_req), .i_b_write_x(z_b_wx), .i_b_addr(z_b_addr), .i_b_data(z_b_data), .i_b_be(z_b_be),
    .o_b_ack(z_b_ack), .o_b_data(z_b_q), .o_busy(z_busy));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit pb, input logic wx, input logic [7:0] ad, input logic [15:0] d,
                     input logic [1:0] be, output int lat);
    @(negedge clk);
    if (pb) begin b_req = 1; b_wx = wx; b_addr = ad; b_data = d; b_be = be; end
    else begin a_req = 1; a_wx = wx; a_addr = ad; a_data = d; a_be = be; end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) begin lat = k; break; end
    end
    a_req = 0;
    b_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, n;
    logic [3:0] ord, ord_exp;
    logic [5:0] ackv, busyv;
    logic seen;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_acks", {14'h0, a_ack, b_ack}, 16'h0);
    chk("rst_a_q", a_q, 16'h0);
    chk("rst_b_q", b_q, 16'h0);
    txn(0, 0, 8'h10, 16'h00A5, 2'b11, lat);
    chk("a_wr_lat", 16'(lat), 16'd4);
    txn(1, 1, 8'h10, 16'h0, 2'b00, lat);
    chk("b_rd_lat", 16'(lat), 16'd4);
    chk("b_rd_data", b_q, 16'h00A5);
    chk("a_q_untouched", a_q, 16'h0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_rst_b_q", b_q, 16'h0);
    chk("async_rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", 16'(busy), 16'h0);
    txn(0, 0, 8'h20, 16'h1234, 2'b11, lat);
    txn(0, 0, 8'h20, 16'hABCD, 2'b10, lat);
    txn(0, 1, 8'h20, 16'h0, 2'b00, lat);
    chk("lane_merge", a_q, 16'hAB34);
    txn(1, 0, 8'h20, 16'hFFFF, 2'b00, lat);
    chk("be0_lat", 16'(lat), 16'd4);
    txn(1, 1, 8'h20, 16'h0, 2'b11, lat);
    chk("be0_nochange", b_q, 16'hAB34);
    txn(0, 0, 8'h20, 16'h0000, 2'b01, lat);
    chk("wr_keeps_q", a_q, 16'hAB34);
    txn(0, 0, 8'h03, 16'h0011, 2'b11, lat);
    @(negedge clk);
    a_req = 1; a_wx = 0; a_addr = 8'h03; a_data = 16'h0055; a_be = 2'b11;
    repeat (2) @(negedge clk);
    #1 rst_n = 0;
    #1 chk("midrst_busy", 16'(busy), 16'h0);
    a_req = 0;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (5) begin @(negedge clk); seen |= a_ack; end
    chk("midrst_no_ack", 16'(seen), 16'h0);
    txn(1, 1, 8'h03, 16'h0, 2'b00, lat);
    chk("midrst_no_write", b_q, 16'h0011);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    a_req = 1; a_wx = 1; a_addr = 8'h03;
    b_req = 1; b_wx = 1; b_addr = 8'h10;
    n = 0;
    ord = '0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (a_ack) begin ord[n] = 1'b0; n++; end
      else if (b_ack) begin ord[n] = 1'b1; n++; end
    end
    a_req = 0;
    b_req = 0;
    chk("arb_count", 16'(n), 16'd4);
`ifdef RAM_RR_ARB_EN
    ord_exp = 4'b1010;
    chk("arb_b_q", b_q, 16'h00A5);
`else
    ord_exp = 4'b0000;
    chk("arb_b_q", b_q, 16'h0000);
`endif
    chk("arb_order", 16'(ord), 16'(ord_exp));
    chk("arb_a_q", a_q, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    busyv[0] = z_busy;
    ackv[0] = z_a_ack;
    z_a_req = 1; z_a_wx = 1; z_a_addr = 4'h2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      busyv[k] = z_busy;
      ackv[k] = z_a_ack;
    end
    z_a_req = 0;
    chk("w0_ack_cycles", 16'(ackv), 16'(6'b100100));
    chk("w0_busy_cycles", 16'(busyv), 16'(6'b110110));
    @(negedge clk);
    chk("w0_idle_after", 16'(z_busy), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
